y_seq_checker: RTL and testbench
================================

Y_SEQ_CHECKER -- requirements
Module: y_seq_checker

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in entries; power of two, at least 2.
REQ-002 Parameter CNT_W, default 8, width of cycle counter.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 in_valid  input  1  upstream FSM presents a code this cycle.
REQ-006 in_code  input  3  code from upstream FSM output; legal values 1..4.
REQ-007 in_ready  output  1  block accepts in_code when in_valid and in_ready are both 1.
REQ-008 out_valid  output  1  FIFO head is valid.
REQ-009 out_code  output  3  FIFO head code.
REQ-010 out_ready  input  1  downstream pops the head when out_valid and out_ready are both 1.
REQ-011 err_clr  input  1  clears the sticky error state.
REQ-012 err  output  1  sticky flag for an illegal code or an illegal transition.
REQ-013 err_code  output  3  the first offending code since the last clear.
REQ-014 cycle_cnt  output  CNT_W  count of completed 4->1 sequences.

Function
REQ-015 Accepting a code ("accept") SHALL mean in_valid and in_ready both 1; in_ready SHALL equal the FIFO's not-full status.
REQ-016 Checker FSM states:
- IDLE: no previous code; after reset or after an error.
- S1, S2, S3, S4: the last legal code was 1, 2, 3 or 4.
REQ-017 From IDLE, only code 1 is legal and it moves the FSM to S1; any other accepted code is an error.
REQ-018 From S1..S4, a repeat of the current code is legal and holds the state.
REQ-019 Legal advancing transitions: 1->2, 2->3, 2->4, 3->4, 4->1; all others, and codes 0, 5, 6 and 7, are errors.
REQ-020 On an error, the FSM SHALL go to IDLE, err SHALL be set, and the offending code SHALL NOT be enqueued.
REQ-021 err_code SHALL capture the offending code only when err was 0 beforehand; later errors SHALL keep the first value.
REQ-022 err_clr SHALL clear err and err_code to 0 on the next edge.
REQ-023 If err_clr and a new error occur in the same cycle, the new error SHALL win: err=1 and err_code = the new code.
REQ-024 Each legal accepted code SHALL be written to the FIFO.
REQ-025 Latency: a code written at edge N SHALL appear at out_code with out_valid=1 after edge N; there is no combinational bypass.
REQ-026 cycle_cnt SHALL increment on each accepted legal 4->1 transition and SHALL saturate at all-ones.
REQ-027 FIFO operation:
- out_valid = not empty.
- Pointers wrap modulo DEPTH.
- Occupancy counter width = log2(DEPTH)+1.
REQ-028 Push and pop in the same cycle when the FIFO is neither empty nor full: occupancy unchanged, both pointers advance.
REQ-029 When the FIFO is full: in_ready=0 and upstream holds; a pop in that cycle frees space for the next cycle only.
REQ-030 When the FIFO is empty: out_code SHALL be 0; a pop request is ignored.

Reset
REQ-031 While reset=0, the following SHALL be held immediately and asynchronously:
- FSM = IDLE.
- FIFO empty, pointers 0.
- out_valid=0, out_code=0.
- in_ready=1 after release.
- err=0, err_code=0, cycle_cnt=0.
REQ-032 Reset asserted mid-stream SHALL discard all FIFO contents and the checker history; the first code after release SHALL be checked from IDLE.

Structure
REQ-033 A shared package SHALL hold the code constants (CODE1..CODE4) and the FSM state encoding, for reuse by the upstream FSM and its bench.
REQ-034 The FIFO SHALL be the single sub-module, code_fifo, parameterised by DEPTH and width 3; the checker logic SHALL live in the top module.

Verification
REQ-035 After reset, stream 1,2,3,4,1 with out_ready=1 -> out_code sequence 1,2,3,4,1, cycle_cnt=1, err=0.
REQ-036 Stream 1,1,2,4,4,1 -> all codes enqueued, cycle_cnt=1, err=0.
REQ-037 Stream 1,3 -> code 3 not enqueued, err=1, err_code=3; then 5 -> err_code stays 3; then err_clr with code 6 in the same cycle -> err=1, err_code=6.
REQ-038 Hold out_ready=0 and push 5 legal codes (DEPTH=4) -> in_ready=0 after 4 accepts; pop once -> the 5th code is accepted on the following cycle.
REQ-039 Drive 256 complete 1..4 cycles with CNT_W=8 -> cycle_cnt saturates at 255.
REQ-040 Assert reset with 3 entries queued and err=1 -> out_valid=0, err=0, cycle_cnt=0 immediately; after release, a first code of 2 -> err=1.

Source files
------------

// File: rtl/y_seq_checker_pkg.sv
// Shared code and state definitions for the y-sequence checker, its upstream FSM and benches.
package y_seq_checker_pkg;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE1 = 3'd1;
  localparam logic [CODE_W-1:0] CODE2 = 3'd2;
  localparam logic [CODE_W-1:0] CODE3 = 3'd3;
  localparam logic [CODE_W-1:0] CODE4 = 3'd4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S1   = 3'd1;
  localparam logic [2:0] ST_S2   = 3'd2;
  localparam logic [2:0] ST_S3   = 3'd3;
  localparam logic [2:0] ST_S4   = 3'd4;

  // A repeat of the current code is legal; IDLE only accepts the start code.
  function automatic logic is_legal(input logic [2:0] st, input logic [CODE_W-1:0] code);
    logic ok;
    ok = 1'b0;
    case (st)
      ST_IDLE: ok = (code == CODE1);
      ST_S1:   ok = (code == CODE1) || (code == CODE2);
      ST_S2:   ok = (code == CODE2) || (code == CODE3) || (code == CODE4);
      ST_S3:   ok = (code == CODE3) || (code == CODE4);
      ST_S4:   ok = (code == CODE4) || (code == CODE1);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] state_for_code(input logic [CODE_W-1:0] code);
    logic [2:0] st;
    st = ST_IDLE;
    case (code)
      CODE1:   st = ST_S1;
      CODE2:   st = ST_S2;
      CODE3:   st = ST_S3;
      CODE4:   st = ST_S4;
      default: st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO holding accepted codes; head reads as zero while empty.
module code_fifo
  import y_seq_checker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CODE_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W + 1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/y_seq_checker.sv
// Checks the code stream of an upstream FSM, queues legal codes and flags the first illegal one.
module y_seq_checker
  import y_seq_checker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             in_ready,
  output logic             out_valid,
  output logic [2:0]       out_code,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready depends only on FIFO fullness, never on in_valid.

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       accept;
  logic       legal;
  logic       bad;
  logic       wrap;
  logic       fifo_full;
  logic       fifo_empty;

  assign fsm_state = state;
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign legal     = is_legal(state, in_code);
  assign bad       = accept && !legal;
  assign wrap      = accept && legal && (state == ST_S4) && (in_code == CODE1);

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = legal ? state_for_code(in_code) : ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A new error outranks a simultaneous clear and re-captures its code.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      err_code <= '0;
    end else if (bad) begin
      err <= 1'b1;
      if (!err || err_clr) err_code <= in_code;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_code <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (wrap && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  code_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(3)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept && legal),
    .push_data (in_code),
    .pop       (out_ready),
    .head      (out_code),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_y_seq_checker.sv
// Directed scoreboard bench for y_seq_checker: driver pushes expected codes, monitor pops on each output transfer.
module tb_y_seq_checker;
  import y_seq_checker_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic [2:0]       in_code;
  logic             in_ready;
  logic             out_valid;
  logic [2:0]       out_code;
  logic             out_ready;
  logic             err_clr;
  logic             err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       fsm_state;

  logic [2:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  y_seq_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err       (err),
    .err_code  (err_code),
    .cycle_cnt (cycle_cnt),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every head transfer is compared against the expected queue.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_extra: got %0d expected no output", out_code);
      end else begin
        check("scoreboard", {29'd0, out_code}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks; all are entered and left at posedge+1.
  task automatic send(input logic [2:0] code, input bit legal);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_code  = code;
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    if (legal) exp_q.push_back(code);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && waited < 200) begin
      @(posedge clock);
      #1;
      waited++;
    end
    check("drain_done", {31'd0, out_valid}, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    exp_q.delete();
    #1;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_code",  {29'd0, out_code}, 32'd0);
    check("rst_err",       {31'd0, err}, 32'd0);
    check("rst_err_code",  {29'd0, err_code}, 32'd0);
    check("rst_cnt",       {24'd0, cycle_cnt}, 32'd0);
    check("rst_state",     {29'd0, fsm_state}, {29'd0, ST_IDLE});
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic legal loop 1,2,3,4,1
    out_ready = 1'b1;
    send(3'd1, 1'b1); send(3'd2, 1'b1); send(3'd3, 1'b1);
    send(3'd4, 1'b1); send(3'd1, 1'b1);
    drain();
    check("t1_cnt", {24'd0, cycle_cnt}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_empty_code", {29'd0, out_code}, 32'd0);

    // Repeats and the 2->4 shortcut
    apply_reset();
    out_ready = 1'b1;
    send(3'd1, 1'b1); send(3'd1, 1'b1); send(3'd2, 1'b1);
    send(3'd4, 1'b1); send(3'd4, 1'b1); send(3'd1, 1'b1);
    drain();
    check("t2_cnt", {24'd0, cycle_cnt}, 32'd1);
    check("t2_err", {31'd0, err}, 32'd0);

    // Error capture, first-code hold, clear collision
    apply_reset();
    out_ready = 1'b1;
    send(3'd1, 1'b1);
    send(3'd3, 1'b0);
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_err_code", {29'd0, err_code}, 32'd3);
    check("t3_state_idle", {29'd0, fsm_state}, {29'd0, ST_IDLE});
    send(3'd5, 1'b0);
    check("t3_err_code_hold", {29'd0, err_code}, 32'd3);
    err_clr = 1'b1;
    send(3'd6, 1'b0);
    err_clr = 1'b0;
    check("t3_clr_vs_err", {31'd0, err}, 32'd1);
    check("t3_clr_vs_err_code", {29'd0, err_code}, 32'd6);
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    check("t3_clr_err", {31'd0, err}, 32'd0);
    check("t3_clr_err_code", {29'd0, err_code}, 32'd0);
    send(3'd1, 1'b1);
    check("t3_restart_state", {29'd0, fsm_state}, {29'd0, ST_S1});
    send(3'd2, 1'b1);
    drain();
    check("t3_no_err", {31'd0, err}, 32'd0);

    // Full FIFO backpressure
    apply_reset();
    out_ready = 1'b0;
    send(3'd1, 1'b1); send(3'd2, 1'b1); send(3'd3, 1'b1); send(3'd4, 1'b1);
    check("t4_full_ready", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b1;
    in_code   = 3'd1;
    out_ready = 1'b1;
    @(negedge clock);
    check("t4_still_full", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("t4_not_taken_state", {29'd0, fsm_state}, {29'd0, ST_S4});
    check("t4_not_taken_cnt", {24'd0, cycle_cnt}, 32'd0);
    @(negedge clock);
    check("t4_ready_after_pop", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(3'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("t4_fifth_state", {29'd0, fsm_state}, {29'd0, ST_S1});
    check("t4_fifth_cnt", {24'd0, cycle_cnt}, 32'd1);
    check("t4_full_again", {31'd0, in_ready}, 32'd0);
    drain();

    // Counter saturation
    apply_reset();
    out_ready = 1'b1;
    send(3'd1, 1'b1);
    for (int i = 1; i <= 256; i++) begin
      send(3'd2, 1'b1); send(3'd3, 1'b1); send(3'd4, 1'b1); send(3'd1, 1'b1);
      if (i == 1)   check("t5_cnt_1", {24'd0, cycle_cnt}, 32'd1);
      if (i == 255) check("t5_cnt_255", {24'd0, cycle_cnt}, 32'd255);
    end
    check("t5_cnt_sat", {24'd0, cycle_cnt}, 32'd255);
    drain();

    // Mid-stream reset
    apply_reset();
    out_ready = 1'b1;
    send(3'd1, 1'b1); send(3'd2, 1'b1); send(3'd3, 1'b1);
    send(3'd4, 1'b1); send(3'd1, 1'b1);
    drain();
    out_ready = 1'b0;
    send(3'd1, 1'b1); send(3'd2, 1'b1); send(3'd3, 1'b1);
    send(3'd7, 1'b0);
    check("t6_pre_err", {31'd0, err}, 32'd1);
    check("t6_pre_cnt", {24'd0, cycle_cnt}, 32'd1);
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_code", {29'd0, out_code}, 32'd0);
    check("t6_rst_err", {31'd0, err}, 32'd0);
    check("t6_rst_cnt", {24'd0, cycle_cnt}, 32'd0);
    check("t6_rst_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send(3'd2, 1'b0);
    check("t6_first_code_err", {31'd0, err}, 32'd1);
    check("t6_first_code_errc", {29'd0, err_code}, 32'd2);
    check("t6_nothing_queued", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
